// File: rtl/bcd_7seg_scanner.sv
// bcd_7seg_scanner
//   Time-multiplexes four BCD digits onto a common-anode 4-digit 7-segment
//   display. Each digit owns a REFRESH_DIV-cycle slot. The first BLANK_CYCLES
//   cycles of every slot keep all anodes off, which suppresses ghosting.
//   Digit values and dp_mask are captured once per frame, at slot 0 and
//   prescaler 0, so the display cannot tear when the inputs change mid-frame.
//
//   Optional feature, macro LEADING_ZERO_BLANK_EN:
//     Leading-zero digits 3..1 are blanked. Digit 0 is never blanked.
//
// Ports
//   clk      system clock
//   rst      asynchronous reset, active-low
//   en       scan enable. Low blanks the display and freezes the scan.
//   bcd1..4  digits 0..3 (bcd1 is least significant)
//   dp_mask  decimal-point request per digit, active-high
//   seg      segments {g,f,e,d,c,b,a}, active-low, registered
//   dp       decimal point, active-low, registered
//   an       anodes, an[k] selects digit k, active-low, registered
module bcd_7seg_scanner #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd4,
  input  logic [3:0] dp_mask,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLK  = CW'(BLANK_CYCLES);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;
  // With BLANK_CYCLES=0 the FSM must never sit in BLANK, not even after reset.
  localparam logic [0:0] ST_RST   = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

  logic [CW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [0:0]    state_q, state_d;
  logic [15:0]   snap_q, snap_d;
  logic [3:0]    dps_q, dps_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic [3:0]    cur;
  logic [6:0]    dec;
  logic          lz_blank;

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    dps_d   = dps_q;
    if (en) begin
      if (presc_q == '0 && idx_q == 2'd0) begin
        snap_d = {bcd4, bcd3, bcd2, bcd1};
        dps_d  = dp_mask;
      end
      if (presc_q == LAST) begin
        presc_d = '0;
        idx_d   = idx_q + 2'd1;
      end else begin
        presc_d = presc_q + CW'(1);
      end
    end
    state_d = (presc_d < BLK) ? ST_BLANK : ST_SHOW;
  end

  // Decode from snap_d so that the digit-0 slot uses the value captured on
  // this edge. This matters when BLANK_CYCLES=0 and the capture cycle is
  // itself visible.
  always_comb begin
    cur = snap_d[idx_q*4 +: 4];
    case (cur)
      4'd0:    dec = 7'h40;
      4'd1:    dec = 7'h79;
      4'd2:    dec = 7'h24;
      4'd3:    dec = 7'h30;
      4'd4:    dec = 7'h19;
      4'd5:    dec = 7'h12;
      4'd6:    dec = 7'h02;
      4'd7:    dec = 7'h78;
      4'd8:    dec = 7'h00;
      4'd9:    dec = 7'h10;
      default: dec = 7'h3F;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    case (idx_q)
      2'd3:    lz_blank = (snap_d[15:12] == 4'h0);
      2'd2:    lz_blank = (snap_d[15:8]  == 8'h00);
      2'd1:    lz_blank = (snap_d[15:4]  == 12'h000);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (en && state_q == ST_SHOW) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = lz_blank ? 7'h7F : dec;
      dp_d  = ~dps_d[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      state_q <= ST_RST;
      snap_q  <= 16'h0000;
      dps_q   <= 4'h0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      an_q    <= 4'b1111;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      snap_q  <= snap_d;
      dps_q   <= dps_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
module tb_bcd_7seg_scanner;
  localparam int RDIV = 8;
  localparam int BLK  = 2;

  logic clk = 1'b0;
  logic rst, en;
  logic [3:0] bcd1, bcd2, bcd3, bcd4, dp_mask;
  logic [6:0] seg;
  logic dp;
  logic [3:0] an;

  bcd_7seg_scanner #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLK)) dut (
    .clk(clk), .rst(rst), .en(en),
    .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3), .bcd4(bcd4),
    .dp_mask(dp_mask), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  int t;             // enabled cycles since reset
  logic [15:0] msnap;
  logic [3:0]  mdp;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic [6:0]  lut [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0d got=%h exp=%h @%0t", tag, t, got, exp, $time);
    end
  endtask

  // One clock. The model computes what the next edge must produce from the
  // inputs currently driven. The outputs are then sampled 1 time unit after
  // that edge.
  task automatic cyc();
    int p, i, d;
    e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
    if (en) begin
      p = t % RDIV;
      i = (t / RDIV) % 4;
      if (t % (4 * RDIV) == 0) begin
        msnap = {bcd4, bcd3, bcd2, bcd1};
        mdp   = dp_mask;
      end
      if (p >= BLK) begin
        d     = (msnap >> (4 * i)) & 15;
        e_an  = ~(4'(1) << i);
        e_seg = lut[d];
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && (msnap >> (4 * i)) == 0) e_seg = 7'h7F;
`endif
        e_dp  = ~mdp[i];
      end
      t++;
    end
    @(posedge clk); #1;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
  endtask

  task automatic set_dig(input logic [3:0] d4, input logic [3:0] d3,
                         input logic [3:0] d2, input logic [3:0] d1);
    bcd4 = d4; bcd3 = d3; bcd2 = d2; bcd1 = d1;
  endtask

  initial begin
    lut[0] = 7'h40; lut[1] = 7'h79; lut[2] = 7'h24; lut[3] = 7'h30;
    lut[4] = 7'h19; lut[5] = 7'h12; lut[6] = 7'h02; lut[7] = 7'h78;
    lut[8] = 7'h00; lut[9] = 7'h10;
    for (int k = 10; k < 16; k++) lut[k] = 7'h3F;

    rst = 1'b0; en = 1'b0; dp_mask = 4'h0; set_dig(0, 0, 0, 0);
    t = 0; msnap = 16'h0; mdp = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);

    // Digits 1,2,3,4. bcd1 changes to 9 during the digit-2 slot.
    rst = 1'b1; en = 1'b1; set_dig(1, 2, 3, 4);
    for (int c = 0; c < 80; c++) begin
      if (c == 2) begin
        chk("first_show_an", 32'(an), 32'hF);
      end
      cyc();
      if (c == 20) bcd1 = 4'd9;
    end

    // Drop en for 5 cycles in the middle of a digit-1 SHOW slot.
    while (t % 32 != 12) cyc();
    en = 1'b0;
    repeat (5) cyc();
    en = 1'b1;
    repeat (40) cyc();

    // Show a dash and a decimal point on digit 2.
    set_dig(1, 12, 3, 4); dp_mask = 4'b0100;
    repeat (70) cyc();

    // Assert reset mid-slot while digit 3 is shown.
    while (t % 32 != 28) cyc();
    rst = 1'b0; #1;
    chk("async_rst_an", 32'(an), 32'hF);
    chk("async_rst_seg", 32'(seg), 32'h7F);
    chk("async_rst_dp", 32'(dp), 32'h1);
    t = 0; msnap = 16'h0; mdp = 4'h0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (40) cyc();

    // Leading-zero patterns.
    dp_mask = 4'h0;
    while (t % 32 != 1) cyc();
    set_dig(0, 0, 0, 7);
    repeat (64) cyc();
    set_dig(0, 5, 0, 0);
    repeat (64) cyc();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) begin
        set_dig(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        dp_mask = 4'($urandom);
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
